// File: rtl/f_le_pkg.sv
// Shared types and helpers for the floating-point less-or-equal responder.
//   EXP_W_DEF / MAN_W_DEF : default exponent / mantissa widths (binary64)
//   f_le_class_t          : per-request classification captured in stage 1
//   is_nan                : NaN test from exponent-all-ones and mantissa-nonzero flags
package f_le_pkg;

   localparam int EXP_W_DEF = 11;
   localparam int MAN_W_DEF = 52;

   typedef struct packed {
      logic nan_a;
      logic nan_b;
      logic sa;
      logic sb;
      logic mag_lt;
      logic mag_eq;
      logic both_zero;
   } f_le_class_t;

   // The exponent/mantissa reductions are done by the caller because the
   // field widths are parameters of the instantiating module.
   function automatic logic is_nan(input logic exp_all_ones, input logic man_nonzero);
      return exp_all_ones & man_nonzero;
   endfunction

endpackage

// File: rtl/f_le_classify.sv
// Combinational operand classification for a <= b.
//   a, b : IEEE-754 style operands, sign in bit FLEN-1
//   cls  : NaN flags, signs, magnitude less-than / equal, both-zero
module f_le_classify
   import f_le_pkg::*;
#(
   parameter int FLEN  = 64,
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic [FLEN-1:0] a,
   input  logic [FLEN-1:0] b,
   output f_le_class_t     cls
);

   logic [EXP_W-1:0] exp_a;
   logic [EXP_W-1:0] exp_b;
   logic [MAN_W-1:0] man_a;
   logic [MAN_W-1:0] man_b;
   logic [FLEN-2:0]  mag_a;
   logic [FLEN-2:0]  mag_b;

   assign exp_a = a[FLEN-2 -: EXP_W];
   assign exp_b = b[FLEN-2 -: EXP_W];
   assign man_a = a[MAN_W-1:0];
   assign man_b = b[MAN_W-1:0];
   assign mag_a = a[FLEN-2:0];
   assign mag_b = b[FLEN-2:0];

   // Sign-magnitude ordering: below the sign bit, exponent-over-mantissa
   // compares as an unsigned integer, which covers subnormals and infinities.
   always_comb begin
      cls           = '0;
      cls.nan_a     = is_nan(&exp_a, |man_a);
      cls.nan_b     = is_nan(&exp_b, |man_b);
      cls.sa        = a[FLEN-1];
      cls.sb        = b[FLEN-1];
      cls.mag_lt    = (mag_a < mag_b);
      cls.mag_eq    = (mag_a == mag_b);
      cls.both_zero = (mag_a == '0) & (mag_b == '0);
   end

endmodule

// File: rtl/f_le_responder.sv
// Pipelined floating-point a <= b responder with valid/ready handshakes.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake carrying req_a, req_b, req_tag
//   rsp_valid/rsp_ready   : response handshake carrying rsp_res, rsp_err, rsp_tag
//   busy                  : any pipeline stage occupied
//   cnt_rsp, cnt_err      : saturating counts of delivered / errored responses
// Stage 1 registers the operand classification, stage 2 is the output register.
module f_le_responder
   import f_le_pkg::*;
#(
   parameter int FLEN  = 64,
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [FLEN-1:0]  req_a,
   input  logic [FLEN-1:0]  req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_res,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_rsp,
   output logic [CNT_W-1:0] cnt_err
);

   f_le_class_t      cls_in;

   logic             s1_valid_q, s1_valid_d;
   f_le_class_t      s1_cls_q,   s1_cls_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_res_q,   rsp_res_d;
   logic             rsp_err_q,   rsp_err_d;
   logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;

   logic [CNT_W-1:0] cnt_rsp_q, cnt_rsp_d;
   logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

   logic             adv1;
   logic             adv2;
   logic             rsp_xfer;
   logic             res_calc;
   logic             err_calc;

   f_le_classify #(
      .FLEN  (FLEN),
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_classify (
      .a   (req_a),
      .b   (req_b),
      .cls (cls_in)
   );

   // Ready is derived from pipeline state and rsp_ready only, never from
   // req_valid, so initiators may wait on it before raising valid.
   assign adv2      = !rsp_valid_q | rsp_ready;
   assign adv1      = !s1_valid_q | adv2;
   assign req_ready = adv1;
   assign rsp_xfer  = rsp_valid_q & rsp_ready;

   always_comb begin
      err_calc = s1_cls_q.nan_a | s1_cls_q.nan_b;
      res_calc = 1'b0;
      if (!err_calc) begin
         unique case ({s1_cls_q.sa, s1_cls_q.sb})
            2'b00:   res_calc = s1_cls_q.mag_lt | s1_cls_q.mag_eq;
            2'b11:   res_calc = !s1_cls_q.mag_lt;
            2'b10:   res_calc = 1'b1;
            2'b01:   res_calc = s1_cls_q.both_zero;  // +0 <= -0
            default: res_calc = 1'b0;
         endcase
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_cls_d    = s1_cls_q;
      s1_tag_d    = s1_tag_q;
      rsp_valid_d = rsp_valid_q;
      rsp_res_d   = rsp_res_q;
      rsp_err_d   = rsp_err_q;
      rsp_tag_d   = rsp_tag_q;
      cnt_rsp_d   = cnt_rsp_q;
      cnt_err_d   = cnt_err_q;

      if (adv1) begin
         s1_valid_d = req_valid;
         if (req_valid) begin
            s1_cls_d = cls_in;
            s1_tag_d = req_tag;
         end
      end

      // Payload only changes when a new entry moves in, so a held or
      // drained output keeps its last values.
      if (adv2) begin
         rsp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            rsp_res_d = res_calc;
            rsp_err_d = err_calc;
            rsp_tag_d = s1_tag_q;
         end
      end

      if (rsp_xfer) begin
         if (cnt_rsp_q != '1) cnt_rsp_d = cnt_rsp_q + CNT_W'(1);
         if (rsp_err_q && (cnt_err_q != '1)) cnt_err_d = cnt_err_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_cls_q    <= '0;
         s1_tag_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_res_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_tag_q   <= '0;
         cnt_rsp_q   <= '0;
         cnt_err_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_cls_q    <= s1_cls_d;
         s1_tag_q    <= s1_tag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_res_q   <= rsp_res_d;
         rsp_err_q   <= rsp_err_d;
         rsp_tag_q   <= rsp_tag_d;
         cnt_rsp_q   <= cnt_rsp_d;
         cnt_err_q   <= cnt_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_res   = rsp_res_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_tag   = rsp_tag_q;
   assign busy      = s1_valid_q | rsp_valid_q;
   assign cnt_rsp   = cnt_rsp_q;
   assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_f_le_responder.sv
// Directed self-checking bench for f_le_responder (binary64, 4-bit tags).
module tb_f_le_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_res;
   logic        rsp_err;
   logic [3:0]  rsp_tag;
   logic        busy;
   logic [15:0] cnt_rsp;
   logic [15:0] cnt_err;

   int n_tests;
   int n_fail;
   int exp_cnt_rsp;
   int exp_cnt_err;

   f_le_responder dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_err   (rsp_err),
      .rsp_tag   (rsp_tag),
      .busy      (busy),
      .cnt_rsp   (cnt_rsp),
      .cnt_err   (cnt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One request from idle with rsp_ready=1; lat counts edges from the
   // drive point until rsp_valid is seen (accept edge included).
   task automatic xact(input logic [63:0] a, input logic [63:0] b, input logic [3:0] t,
                       output logic res, output logic err, output logic [3:0] tg,
                       output int lat);
      req_a = a; req_b = b; req_tag = t; req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      res = rsp_res; err = rsp_err; tg = rsp_tag;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({rsp_valid, rsp_res, rsp_err, rsp_tag, busy} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b r=%b e=%b t=%h busy=%b want all 0",
                  rsp_valid, rsp_res, rsp_err, rsp_tag, busy);
      end
      n_tests++;
      if (cnt_rsp !== 16'h0 || cnt_err !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_counters: got %h/%h want 0000/0000", cnt_rsp, cnt_err);
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_req_ready: got %b want 1", req_ready);
      end
      exp_cnt_rsp = 0; exp_cnt_err = 0;
   endtask

   task automatic test_single;
      logic r, e; logic [3:0] tg; int lat;
      req_a = 64'h3FF0000000000000; req_b = 64'h4000000000000000; req_tag = 4'd3;
      req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_stage1: got busy=%b v=%b want busy=1 v=0", busy, rsp_valid);
      end
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      r = rsp_res; e = rsp_err; tg = rsp_tag;
      @(posedge clk); #1;
      exp_cnt_rsp++;
      n_tests++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL single_latency: got %0d edges want 2", lat);
      end
      n_tests++;
      if ({r, e, tg} !== {1'b1, 1'b0, 4'd3}) begin
         n_fail++;
         $display("FAIL single_result: got res=%b err=%b tag=%h want 1 0 3", r, e, tg);
      end
      n_tests++;
      if (cnt_rsp !== 16'(exp_cnt_rsp) || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_cnt: got cnt=%0d busy=%b want %0d busy=0", cnt_rsp, busy, exp_cnt_rsp);
      end
   endtask

   task automatic test_signs;
      logic [63:0] va [10];
      logic [63:0] vb [10];
      logic        vr [10];
      logic r, e; logic [3:0] tg; int lat;
      va[0] = 64'hBFF0000000000000; vb[0] = 64'h3FF0000000000000; vr[0] = 1'b1;
      va[1] = 64'h4000000000000000; vb[1] = 64'h3FF0000000000000; vr[1] = 1'b0;
      va[2] = 64'h8000000000000000; vb[2] = 64'h0000000000000000; vr[2] = 1'b1;
      va[3] = 64'h0000000000000000; vb[3] = 64'h8000000000000000; vr[3] = 1'b1;
      va[4] = 64'h7FF0000000000000; vb[4] = 64'h7FF0000000000000; vr[4] = 1'b1;
      va[5] = 64'hBFF0000000000000; vb[5] = 64'hC000000000000000; vr[5] = 1'b0;
      va[6] = 64'hFFF0000000000000; vb[6] = 64'h7FF0000000000000; vr[6] = 1'b1;
      va[7] = 64'h0000000000000001; vb[7] = 64'h0000000000000000; vr[7] = 1'b0;
      va[8] = 64'h3FF0000000000000; vb[8] = 64'h3FF0000000000000; vr[8] = 1'b1;
      va[9] = 64'h0000000000000001; vb[9] = 64'h8000000000000000; vr[9] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         xact(va[i], vb[i], i[3:0], r, e, tg, lat);
         exp_cnt_rsp++;
         n_tests++;
         if ({r, e, tg} !== {vr[i], 1'b0, i[3:0]}) begin
            n_fail++;
            $display("FAIL sign_case_%0d: got res=%b err=%b tag=%h want res=%b err=0 tag=%h",
                     i, r, e, tg, vr[i], i[3:0]);
         end
      end
      n_tests++;
      if (cnt_rsp !== 16'(exp_cnt_rsp) || cnt_err !== 16'(exp_cnt_err)) begin
         n_fail++;
         $display("FAIL sign_cnt: got %0d/%0d want %0d/%0d", cnt_rsp, cnt_err, exp_cnt_rsp, exp_cnt_err);
      end
   endtask

   task automatic test_nan;
      logic r, e; logic [3:0] tg; int lat;
      xact(64'h7FF8000000000000, 64'h0, 4'd5, r, e, tg, lat);
      exp_cnt_rsp++; exp_cnt_err++;
      n_tests++;
      if ({r, e, tg} !== {1'b0, 1'b1, 4'd5}) begin
         n_fail++;
         $display("FAIL nan_a: got res=%b err=%b tag=%h want 0 1 5", r, e, tg);
      end
      n_tests++;
      if (cnt_err !== 16'(exp_cnt_err)) begin
         n_fail++;
         $display("FAIL nan_a_cnt_err: got %0d want %0d", cnt_err, exp_cnt_err);
      end
      xact(64'h0, 64'hFFF0000000000001, 4'd6, r, e, tg, lat);
      exp_cnt_rsp++; exp_cnt_err++;
      n_tests++;
      if ({r, e, tg} !== {1'b0, 1'b1, 4'd6} || cnt_err !== 16'(exp_cnt_err)) begin
         n_fail++;
         $display("FAIL nan_b: got res=%b err=%b tag=%h cnt_err=%0d want 0 1 6 %0d",
                  r, e, tg, cnt_err, exp_cnt_err);
      end
   endtask

   task automatic test_backpressure;
      int idx, n;
      logic [3:0] got_tag [4];
      logic       got_res [4];
      int extra;
      idx = 0; n = 0; extra = 0;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_a = 64'h3FF0000000000000; req_b = 64'h4000000000000000; req_tag = 4'd0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         if (c == 2 || c == 5) begin
            n_tests++;
            if ({rsp_valid, rsp_tag, rsp_res, rsp_err} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
               n_fail++;
               $display("FAIL bp_hold_c%0d: got v=%b tag=%h res=%b err=%b want 1 0 1 0",
                        c, rsp_valid, rsp_tag, rsp_res, rsp_err);
            end
         end
         if (c == 5) begin
            n_tests++;
            if (idx !== 2 || req_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_stall: got accepted=%0d req_ready=%b want 2 0", idx, req_ready);
            end
            rsp_ready = 1'b1;
            #1;
         end
         if (rsp_valid && rsp_ready) begin
            got_tag[n] = rsp_tag; got_res[n] = rsp_res; n++;
         end
         if (req_valid && req_ready) idx++;
         @(posedge clk); #1;
         if (idx < 4) begin
            req_a   = idx[0] ? 64'h4000000000000000 : 64'h3FF0000000000000;
            req_b   = idx[0] ? 64'h3FF0000000000000 : 64'h4000000000000000;
            req_tag = idx[3:0];
         end else begin
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (rsp_valid) extra++;
         @(posedge clk); #1;
      end
      exp_cnt_rsp += 4;
      n_tests++;
      if (n !== 4 || extra !== 0) begin
         n_fail++;
         $display("FAIL bp_count: got %0d responses, %0d extra want 4, 0", n, extra);
      end
      for (int i = 0; i < n; i++) begin
         n_tests++;
         if (got_tag[i] !== i[3:0] || got_res[i] !== !i[0]) begin
            n_fail++;
            $display("FAIL bp_order_%0d: got tag=%h res=%b want tag=%h res=%b",
                     i, got_tag[i], got_res[i], i[3:0], !i[0]);
         end
      end
      n_tests++;
      if (cnt_rsp !== 16'(exp_cnt_rsp)) begin
         n_fail++;
         $display("FAIL bp_cnt: got %0d want %0d", cnt_rsp, exp_cnt_rsp);
      end
   endtask

   task automatic test_throughput;
      int idx, n, first, last, bad, stalls;
      idx = 0; n = 0; first = -1; last = -1; bad = 0; stalls = 0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 60 && n < 16; c++) begin
         if (idx < 16) begin
            req_valid = 1'b1; req_a = 64'(idx); req_b = 64'd8; req_tag = idx[3:0];
         end else begin
            req_valid = 1'b0;
         end
         if (rsp_valid) begin
            if (rsp_tag !== n[3:0] || rsp_res !== (n <= 8) || rsp_err !== 1'b0) bad++;
            if (first < 0) first = c;
            last = c;
            n++;
         end
         if (req_valid) begin
            if (req_ready) idx++;
            else stalls++;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      exp_cnt_rsp += 16;
      n_tests++;
      if (n !== 16 || first !== 2 || (last - first) !== 15) begin
         n_fail++;
         $display("FAIL tp_rate: got n=%0d first=%0d span=%0d want 16 2 15", n, first, last - first);
      end
      n_tests++;
      if (bad !== 0 || stalls !== 0) begin
         n_fail++;
         $display("FAIL tp_data: got %0d bad responses, %0d stalls want 0 0", bad, stalls);
      end
      n_tests++;
      if (cnt_rsp !== 16'(exp_cnt_rsp)) begin
         n_fail++;
         $display("FAIL tp_cnt: got %0d want %0d", cnt_rsp, exp_cnt_rsp);
      end
   endtask

   task automatic test_reset_midflight;
      int stale;
      stale = 0;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_a = 64'h7FF8000000000000; req_b = 64'h0; req_tag = 4'd9;
      @(posedge clk); #1;
      req_tag = 4'd10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      exp_cnt_rsp = 0; exp_cnt_err = 0;
      n_tests++;
      if ({rsp_valid, busy, req_ready} !== 3'b001 || cnt_rsp !== 16'h0 || cnt_err !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_mid_state: got v=%b busy=%b rdy=%b cnt=%h/%h want 0 0 1 0000/0000",
                  rsp_valid, busy, req_ready, cnt_rsp, cnt_err);
      end
      rst = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (rsp_valid || busy) stale++;
      end
      n_tests++;
      if (stale !== 0 || cnt_rsp !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_mid_stale: got %0d stale cycles cnt=%0d want 0 0", stale, cnt_rsp);
      end
   endtask

   task automatic test_saturation;
      int nxf;
      nxf = 0;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_a = 64'h7FF8000000000000; req_b = 64'h0; req_tag = 4'd1;
      for (int c = 0; c < 65538; c++) begin
         if (rsp_valid) nxf++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (rsp_valid) nxf++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (nxf !== 65538) begin
         n_fail++;
         $display("FAIL sat_transfers: got %0d want 65538", nxf);
      end
      n_tests++;
      if (cnt_rsp !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_cnt_rsp: got %h want FFFF", cnt_rsp);
      end
      n_tests++;
      if (cnt_err !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_cnt_err: got %h want FFFF", cnt_err);
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      exp_cnt_rsp = 0; exp_cnt_err = 0;
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_tag = '0;
      test_reset;
      test_single;
      test_signs;
      test_nan;
      test_backpressure;
      test_throughput;
      test_reset_midflight;
      test_saturation;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
